// File: rtl/serial_mac_if.sv
// Operand/result bus for serial_mac_accumulator: one valid/ready channel in, one out.
// Both channels: a transfer occurs on a rising edge where valid & ready are both high;
// a source holds its payload stable while valid is high and ready is low.
interface serial_mac_if #(
    parameter int OPW   = 4,
    parameter int ACC_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [OPW-1:0]   in_a;
    logic [OPW-1:0]   in_b;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/serial_mac_accumulator.sv
// Serial multiply-accumulate: one registered multiplier feeding one wrap-around adder,
// summing COUNT operand products per run and holding the result until accepted.
module serial_mac_accumulator #(
    parameter int OPW   = 4,
    parameter int ACC_W = 8,
    parameter int COUNT = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    serial_mac_if.slave  bus,
    output logic         busy,
    output logic [1:0]   dbg_state
);
    localparam int          PW   = 2 * OPW;
    localparam logic [15:0] LAST = 16'(COUNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_n;
    logic             clear;
    logic             accept;
    logic [PW-1:0]    prod_r;
    logic             prod_v;
    logic [ACC_W-1:0] prod_ext;
    logic             trunc_nz;
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   sum;
    logic             ovf;
    logic [15:0]      count;

    // Narrow accumulators drop the product's upper bits; losing a nonzero bit is an overflow too.
    generate
        if (PW > ACC_W) begin : g_trunc
            assign prod_ext = prod_r[ACC_W-1:0];
            assign trunc_nz = |prod_r[PW-1:ACC_W];
        end else begin : g_ext
            assign prod_ext = ACC_W'(prod_r);
            assign trunc_nz = 1'b0;
        end
    endgenerate

    assign sum = {1'b0, acc} + {1'b0, prod_ext};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        clear   = 1'b0;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clear   = 1'b1;
                    state_n = ACCUM;
                end
            end
            ACCUM: begin
                if (bus.in_valid) begin
                    accept = 1'b1;
                    if (count == LAST) begin
                        state_n = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_n = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    if (start) begin
                        clear   = 1'b1;
                        state_n = ACCUM;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // The product registered on an accepting edge is folded into acc on the following edge,
    // which is why the last beat needs the DRAIN cycle before the result is complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            ovf    <= 1'b0;
            count  <= '0;
            prod_r <= '0;
            prod_v <= 1'b0;
        end else if (clear) begin
            acc    <= '0;
            ovf    <= 1'b0;
            count  <= '0;
            prod_v <= 1'b0;
        end else begin
            if (prod_v) begin
                acc <= sum[ACC_W-1:0];
                if (sum[ACC_W] || trunc_nz) begin
                    ovf <= 1'b1;
                end
            end
            prod_v <= accept;
            if (accept) begin
                prod_r <= PW'(bus.in_a) * PW'(bus.in_b);
                count  <= count + 16'd1;
            end
        end
    end

    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == DONE);
    assign bus.out_sum   = acc;
    assign bus.out_ovf   = ovf;
    assign busy          = (state != IDLE);
    assign dbg_state     = state;
endmodule

// File: tb/tb_serial_mac_accumulator.sv
// Bench for serial_mac_accumulator: directed runs on a COUNT=128 instance and a COUNT=1
// instance, with results checked by queue-driven monitors.
module tb_serial_mac_accumulator;
    localparam int OPW   = 4;
    localparam int ACC_W = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       start1;
    logic       busy;
    logic       busy1;
    logic [1:0] dbg_state;
    logic [1:0] dbg_state1;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    logic [ACC_W:0] exp_q[$];
    int             lat_q[$];
    logic [ACC_W:0] exp1_q[$];
    int             lat1_q[$];

    serial_mac_if #(.OPW(OPW), .ACC_W(ACC_W)) bus ();
    serial_mac_if #(.OPW(OPW), .ACC_W(ACC_W)) bus1 ();

    serial_mac_accumulator #(.OPW(OPW), .ACC_W(ACC_W), .COUNT(128)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bus       (bus),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    serial_mac_accumulator #(.OPW(OPW), .ACC_W(ACC_W), .COUNT(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start1),
        .bus       (bus1),
        .busy      (busy1),
        .dbg_state (dbg_state1)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // drivers
    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Offers n beats; accepted beats are those seen with in_valid & in_ready mid-cycle.
    task automatic send_beats(input int n, input int a, input int b, input bit bubbles,
                              input bit do_push, input logic [ACC_W:0] expected);
        int accepted = 0;
        int guard    = 0;
        int last_cyc = 0;
        while (accepted < n && guard < 5000) begin
            bus.in_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_a     = OPW'(a);
            bus.in_b     = OPW'(b);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) begin
                accepted++;
                last_cyc = cyc;
            end
            guard++;
            @(posedge clk);
            #1;
        end
        check("beats_accepted", accepted, n);
        if (do_push) begin
            exp_q.push_back(expected);
            lat_q.push_back(last_cyc + 2);
            bus.in_valid = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check("in_ready_after_last", 32'(bus.in_ready), 0);
                @(posedge clk);
                #1;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 500);
        check("run_end_idle", 32'(busy), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        check({tag, "_out_sum"}, 32'(bus.out_sum), 0);
        check({tag, "_out_ovf"}, 32'(bus.out_ovf), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_state"}, 32'(dbg_state), 0);
    endtask

    // scoreboard monitors: pop on each rising out_valid, check stability while held
    logic             prev_valid = 1'b0;
    logic [ACC_W-1:0] prev_sum;
    logic             prev_ovf;
    logic [ACC_W:0]   e;
    int               l;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.out_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'(bus.out_sum), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    l = lat_q.pop_front();
                    check("out_sum", 32'(bus.out_sum), 32'(e[ACC_W-1:0]));
                    check("out_ovf", 32'(bus.out_ovf), 32'(e[ACC_W]));
                    check("out_latency", cyc, l);
                end
            end else if (bus.out_valid && prev_valid) begin
                check("held_sum", 32'(bus.out_sum), 32'(prev_sum));
                check("held_ovf", 32'(bus.out_ovf), 32'(prev_ovf));
            end
            prev_valid = bus.out_valid && !bus.out_ready;
            prev_sum   = bus.out_sum;
            prev_ovf   = bus.out_ovf;
        end
    end

    logic           prev_valid1 = 1'b0;
    logic [ACC_W:0] e1;
    int             l1;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid1 = 1'b0;
        end else begin
            if (bus1.out_valid && !prev_valid1) begin
                if (exp1_q.size() == 0) begin
                    check("unexpected_result1", 32'(bus1.out_sum), 32'hFFFF_FFFF);
                end else begin
                    e1 = exp1_q.pop_front();
                    l1 = lat1_q.pop_front();
                    check("out_sum_c1", 32'(bus1.out_sum), 32'(e1[ACC_W-1:0]));
                    check("out_ovf_c1", 32'(bus1.out_ovf), 32'(e1[ACC_W]));
                    check("out_latency_c1", cyc, l1);
                end
            end
            prev_valid1 = bus1.out_valid && !bus1.out_ready;
        end
    end

    // directed sequence
    initial begin
        int n;
        rst_n          = 1'b0;
        start          = 1'b0;
        start1         = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_a       = '0;
        bus.in_b       = '0;
        bus.out_ready  = 1'b1;
        bus1.in_valid  = 1'b0;
        bus1.in_a      = '0;
        bus1.in_b      = '0;
        bus1.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs_zero("reset");

        // 128 x (1*1) = 0x80, no carry
        pulse_start();
        send_beats(128, 1, 1, 1'b0, 1'b1, {1'b0, 8'h80});
        wait_idle();

        // 128 x 2 = 256 wraps to 0; 128 x 225 = 28800 -> 0x80 with carry
        pulse_start();
        send_beats(128, 1, 2, 1'b0, 1'b1, {1'b1, 8'h00});
        wait_idle();
        pulse_start();
        send_beats(128, 15, 15, 1'b0, 1'b1, {1'b1, 8'h80});
        wait_idle();

        // bubbles: 128 x 15 = 1920 -> 0x80 with carry
        pulse_start();
        send_beats(128, 3, 5, 1'b1, 1'b1, {1'b1, 8'h80});
        wait_idle();

        // held result: 128 x 3 = 384 -> 0x80 with carry, out_ready low
        bus.out_ready = 1'b0;
        pulse_start();
        send_beats(128, 1, 3, 1'b0, 1'b1, {1'b1, 8'h80});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.out_valid), 1);
            check("hold_sum", 32'(bus.out_sum), 32'h80);
        end
        @(posedge clk);
        #1;
        pulse_start();
        @(negedge clk);
        check("start_no_ready_valid", 32'(bus.out_valid), 1);
        check("start_no_ready_state", 32'(dbg_state), 3);
        check("start_no_ready_in_ready", 32'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        start         = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("b2b_out_valid", 32'(bus.out_valid), 0);
        check("b2b_in_ready", 32'(bus.in_ready), 1);
        check("b2b_state", 32'(dbg_state), 1);
        check("b2b_sum_cleared", 32'(bus.out_sum), 0);
        check("b2b_ovf_cleared", 32'(bus.out_ovf), 0);
        @(posedge clk);
        #1;
        send_beats(128, 1, 1, 1'b0, 1'b1, {1'b0, 8'h80});
        wait_idle();

        // reset after 60 beats, then a clean run: 128 x 2 = 256 -> 0 with carry
        pulse_start();
        send_beats(60, 1, 1, 1'b0, 1'b0, '0);
        @(negedge clk);
        check("pre_reset_busy", 32'(busy), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrun_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        pulse_start();
        send_beats(128, 2, 1, 1'b0, 1'b1, {1'b1, 8'h00});
        wait_idle();

        // COUNT=1 instance: one beat 7*9 = 63
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1        = 1'b0;
        bus1.in_valid = 1'b1;
        bus1.in_a     = 4'd7;
        bus1.in_b     = 4'd9;
        @(negedge clk);
        check("c1_in_ready", 32'(bus1.in_ready), 1);
        exp1_q.push_back({1'b0, 8'h3F});
        lat1_q.push_back(cyc + 2);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("c1_in_ready_after", 32'(bus1.in_ready), 0);
        bus1.in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy1 && n < 50);
        check("c1_idle", 32'(busy1), 0);
        check("c1_state", 32'(dbg_state1), 0);

        repeat (3) @(negedge clk);
        check("results_pending", exp_q.size(), 0);
        check("results_pending_c1", exp1_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_mac_accumulator.md
Name: serial_mac_accumulator

Overview:
Time-multiplexed multiply-accumulate stage that feeds the result path of the tile. It takes a stream of 4-bit operand pairs over a valid/ready handshake and multiplies each pair in a single registered product stage. It accumulates COUNT products modulo 2^ACC_W, then presents the dot-product sum on a held valid/ready output. It replaces the wide parallel multiplier/adder-tree structure with one multiplier and one adder, while keeping the same wrap-around arithmetic.

Parameters:
OPW, 4, operand width in bits (in_a, in_b)
ACC_W, 8, accumulator/result width; sum wraps modulo 2^ACC_W
COUNT, 128, products per run; legal range 1..2^16-1

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle run request; clears accumulator and begins a run
in_valid  input  1  operand pair valid
in_ready  output  1  block accepts operand pair this cycle
in_a  input  OPW  unsigned operand A
in_b  input  OPW  unsigned operand B
out_valid  output  1  result valid; held until accepted
out_ready  input  1  downstream accepts result
out_sum  output  ACC_W  accumulated sum modulo 2^ACC_W
out_ovf  output  1  sticky: a carry out of ACC_W occurred during this run
busy  output  1  high in ACCUM, DRAIN or DONE

Behaviour:
- One clock domain. rst_n is asynchronous assert; all flops reset.
- Reset values: state=IDLE, in_ready=0, out_valid=0, out_sum=0, out_ovf=0, busy=0, beat count=0, product-valid=0.
- FSM states:
  - IDLE: in_ready=0. start=1 → clear acc, ovf, count and product-valid; go to ACCUM.
  - ACCUM: in_ready=1, driven combinationally from state only, never from in_valid. A beat is accepted when in_valid & in_ready. At an accepting edge, prod_r <= in_a*in_b (2*OPW bits, zero-extended), prod_v <= 1, count++. A non-accepting edge sets prod_v <= 0. The edge that accepts beat number COUNT transitions to DRAIN, so in_ready is low the following cycle.
  - DRAIN: one cycle. The final product is added at this edge; go to DONE.
  - DONE: out_valid=1 and out_sum = acc, both stable until out_valid & out_ready. On handshake → IDLE, out_valid=0 next cycle.
- Accumulate rule: every edge with prod_v=1 does acc <= (acc + prod_r) mod 2^ACC_W. If the true sum is ≥ 2^ACC_W, set ovf; ovf stays set until the next start.
- If 2*OPW > ACC_W, the product is truncated to ACC_W bits before the add, and ovf is also set if any truncated bit is nonzero.
- Latency: out_valid rises exactly 2 cycles after the edge accepting beat COUNT. In-stream bubbles (in_valid=0) add cycles but never change the result.
- start during ACCUM or DRAIN: ignored, and the run continues.
- start in DONE without out_ready: ignored.
- start in DONE with out_ready in the same cycle: the result handshake completes and a new run starts. The next state is ACCUM with acc/ovf/count cleared, so back-to-back runs have no IDLE cycle.
- in_valid outside ACCUM: ignored; no beat is consumed.
- Reset mid-run: immediate return to reset values; the partial sum is discarded and no out_valid is produced.
- COUNT=1: a single beat goes to DRAIN, and out_valid appears 2 cycles after acceptance.

Test Plan:
- Reset, start, then 128 back-to-back beats a=1, b=1 → out_valid exactly 2 cycles after the last accept, out_sum=0x80, out_ovf=0; in_ready low from the cycle after the last accept.
- start, 128 beats a=1, b=2 → out_sum=0x00, out_ovf=1. start, 128 beats a=15, b=15 → out_sum=0x80, out_ovf=1.
- start, 128 beats a=3, b=5 with in_valid randomly deasserted ~50% of cycles → out_sum=0x80 (1920 mod 256); exactly 128 beats consumed; extra in_valid after beat 128 is not accepted.
- Result ready, out_ready held low 10 cycles → out_valid and out_sum stable all 10 cycles. Then pulse start with out_ready low → ignored. Then start and out_ready together → new run begins next cycle, out_sum of the new run independent of the old one.
- Assert rst_n low after 60 accepted beats → all outputs 0 asynchronously. Then start and 128 beats a=2, b=1 → out_sum=0x00, out_ovf=1 (256 wraps); no stale carry-over.
- COUNT=1 build: start, one beat a=7, b=9 → out_sum=63 (0x3F), out_ovf=0, out_valid 2 cycles after acceptance.
